// File: rtl/addr_dec_pkg.sv
// addr_dec_pkg: shared FSM states, target/error encodings and region patterns
package addr_dec_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DONE, ERR} state_t;
    typedef logic [1:0] tgt_t;
    localparam tgt_t TGT_NONE = 2'b00;
    localparam tgt_t TGT_A = 2'b01;
    localparam tgt_t TGT_B = 2'b10;
    localparam logic [1:0] ERR_DEC = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;
    localparam logic [3:0] REGION_A = 4'b101?;
    localparam logic [3:0] REGION_B = 4'b001?;
endpackage

// File: rtl/addr_region_decoder.sv
// addr_region_decoder: wildcard address-to-target region decode
// Ports: addr (4-bit address), tgt_sel (one-hot target, 0 on miss), hit (address maps to a target)
module addr_region_decoder
    import addr_dec_pkg::*;
(
    input  logic [3:0] addr,
    output tgt_t       tgt_sel,
    output logic       hit
);
    always_comb begin
        casez (addr)
            REGION_A: tgt_sel = TGT_A;
            REGION_B: tgt_sel = TGT_B;
            default:  tgt_sel = TGT_NONE;
        endcase
    end
    assign hit = tgt_sel != TGT_NONE;
endmodule

// File: rtl/addr_decode_arbiter.sv
// addr_decode_arbiter: round-robin arbiter that decodes the winner's address and sequences it to a shared target
// Ports: clk/rst (sync, active high); req/addr per requester; gnt/ack/err per requester with err_code;
//        tgt_sel/tgt_valid/tgt_ready/tgt_done target handshake; busy whenever not idle
module addr_decode_arbiter
    import addr_dec_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        err,
    output logic [1:0]              err_code,
    output logic [1:0]              tgt_sel,
    output logic                    tgt_valid,
    input  logic                    tgt_ready,
    input  logic                    tgt_done,
    output logic                    busy
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t           state, state_n;
    logic [IDX_W-1:0] rr_ptr, win, owner;
    logic [CNT_W-1:0] cnt;
    tgt_t             tgt_q, dec_sel;
    logic [1:0]       code_q;
    logic             dec_hit, active, expired;
    logic [N_REQ-1:0] owner_oh;

    // Reverse scan so the requester closest above rr_ptr is the last (winning) assignment.
    always_comb begin
        win = rr_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(rr_ptr) + i) % N_REQ]) win = IDX_W'((int'(rr_ptr) + i) % N_REQ);
        end
    end

    addr_region_decoder u_dec (
        .addr    (addr[int'(win) * ADDR_W +: ADDR_W]),
        .tgt_sel (dec_sel),
        .hit     (dec_hit)
    );

    assign expired = cnt == CNT_W'(TIMEOUT - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|req) state_n = dec_hit ? ISSUE : ERR;
            ISSUE:   if (tgt_ready) state_n = BUSY;
            BUSY:    state_n = tgt_done ? DONE : expired ? ERR : BUSY;
            DONE:    state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            tgt_q  <= TGT_NONE;
            code_q <= 2'b00;
            cnt    <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && |req) begin
                owner  <= win;
                tgt_q  <= dec_sel;
                code_q <= ERR_DEC;
            end
            // Only matters if BUSY exits to ERR, which can then only be a timeout.
            if (state == BUSY) code_q <= ERR_TMO;
            if (state == ISSUE) cnt <= '0;
            else if (state == BUSY) cnt <= cnt + 1'b1;
            if (state == DONE || state == ERR) rr_ptr <= (int'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;
        end
    end

    assign active    = state == ISSUE || state == BUSY;
    assign owner_oh  = N_REQ'(1) << owner;
    assign gnt       = active ? owner_oh : '0;
    assign ack       = state == DONE ? owner_oh : '0;
    assign err       = state == ERR ? owner_oh : '0;
    assign err_code  = state == ERR ? code_q : 2'b00;
    assign tgt_sel   = active ? tgt_q : TGT_NONE;
    assign tgt_valid = state == ISSUE;
    assign busy      = state != IDLE;
endmodule
